// File: rtl/o_tracker_pkg.sv
// Shared types and default raster timing for the scope timing tracker.
package o_tracker_pkg;

  typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} lock_state_e;

  localparam int unsigned HVisible    = 576;
  localparam int unsigned HFrontPorch = 136;
  localparam int unsigned HSyncWidth  = 64;
  localparam int unsigned HBackPorch  = 24;
  localparam int unsigned HTotal      = 800;

  localparam int unsigned VVisible    = 378;
  localparam int unsigned VFrontPorch = 25;
  localparam int unsigned VSyncWidth  = 3;
  localparam int unsigned VBackPorch  = 11;
  localparam int unsigned VTotal      = 417;

  // Clocks per polarity-detection window.
  localparam int unsigned PolWindow   = 1024;

endpackage

// File: rtl/o_sync_edge.sv
// Two-flop synchroniser plus inactive-to-active edge detect for one raw sync.
// With O_TRACKER_POLDET_EN defined, the active level is the per-window minority level.
module o_sync_edge
  import o_tracker_pkg::*;
#(
  parameter logic POL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic active_o,
  output logic edge_o,
  output logic pol_chg_o
);

  logic s1_q, s2_q, act_q, pol;

`ifdef O_TRACKER_POLDET_EN
  localparam int unsigned WinW = $clog2(PolWindow);
  localparam int unsigned CntW = WinW + 1;
  localparam logic        SyncRst = ~POL;

  logic            pol_q, pol_chg_q, new_pol;
  logic [WinW-1:0] win_q;
  logic [CntW-1:0] hi_q, hi_sum;

  assign hi_sum  = hi_q + CntW'(s2_q);
  // A sync pulse is the short part of the period, so the rarer level is the active one.
  assign new_pol = (32'(hi_sum) < PolWindow / 2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pol_q     <= POL;
      pol_chg_q <= 1'b0;
      win_q     <= '0;
      hi_q      <= '0;
    end else begin
      win_q     <= win_q + WinW'(1);
      pol_chg_q <= 1'b0;
      if (win_q == '1) begin
        hi_q <= '0;
        if (new_pol != pol_q) begin
          pol_q     <= new_pol;
          pol_chg_q <= 1'b1;
        end
      end else begin
        hi_q <= hi_sum;
      end
    end
  end

  assign pol       = pol_q;
  assign pol_chg_o = pol_chg_q;
`else
  localparam logic SyncRst = ~POL;

  assign pol       = POL;
  assign pol_chg_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q  <= SyncRst;
      s2_q  <= SyncRst;
      act_q <= 1'b0;
    end else begin
      s1_q  <= sig_i;
      s2_q  <= s1_q;
      act_q <= active_o;
    end
  end

  assign active_o = (s2_q == pol);
  assign edge_o   = active_o & ~act_q;

endmodule

// File: rtl/o_timing_tracker.sv
// Recovers raster X/Y, visible window and frame lock from raw scope HS/VS.
// Define O_TRACKER_POLDET_EN to auto-detect sync polarity instead of HS_POL/VS_POL.
module o_timing_tracker
  import o_tracker_pkg::*;
#(
  parameter int unsigned XW            = 10,
  parameter int unsigned YW            = 9,
  parameter int unsigned H_FRONT_PORCH = HFrontPorch,
  parameter int unsigned H_VISIBLE     = HVisible,
  parameter int unsigned V_FRONT_PORCH = VFrontPorch,
  parameter int unsigned V_VISIBLE     = VVisible,
  parameter logic        HS_POL        = 1'b0,
  parameter logic        VS_POL        = 1'b0,
  parameter int unsigned PULSE_DIV     = 60,
  parameter int unsigned SYNC_LINE     = 12,
  parameter int unsigned LOCK_FRAMES   = 3,
  parameter int unsigned TO_W          = 20
) (
  input  logic          O_CLK,
  input  logic          RST,
  input  logic          ENABLE,
  input  logic          O_HS,
  input  logic          O_VS,
  output logic [XW-1:0] O_X,
  output logic [YW-1:0] O_Y,
  output logic          O_VISIBLE,
  output logic          PULSE_1HZ,
  output logic          SYNC,
  output logic          LOCKED,
  output logic [YW-1:0] LINES_PER_FRAME
);

  localparam int unsigned MW     = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned FW     = $clog2(PULSE_DIV) + 1;
  localparam int unsigned HStart = H_FRONT_PORCH - 1;
  localparam int unsigned HEnd   = H_FRONT_PORCH + H_VISIBLE - 1;
  localparam int unsigned VStart = V_FRONT_PORCH;
  localparam int unsigned VEnd   = V_FRONT_PORCH + V_VISIBLE;

  logic hs_act, hs_edge, hs_pchg, vs_act, vs_edge, vs_pchg;
  logic vs_ev, timeout, in_win;

  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q, ref_lines_q;
  logic [FW-1:0]   frame_q;
  logic [MW-1:0]   match_q;
  logic [TO_W-1:0] to_q;
  lock_state_e     state_q;

  o_sync_edge #(.POL(HS_POL)) u_hs (
    .clk_i     (O_CLK),
    .rst_i     (RST),
    .sig_i     (O_HS),
    .active_o  (hs_act),
    .edge_o    (hs_edge),
    .pol_chg_o (hs_pchg)
  );

  o_sync_edge #(.POL(VS_POL)) u_vs (
    .clk_i     (O_CLK),
    .rst_i     (RST),
    .sig_i     (O_VS),
    .active_o  (vs_act),
    .edge_o    (vs_edge),
    .pol_chg_o (vs_pchg)
  );

  assign vs_ev   = vs_edge & ENABLE;
  assign timeout = (to_q == '1);
  assign in_win  = (32'(x_q) >= HStart) && (32'(x_q) < HEnd) &&
                   (32'(y_q) >= VStart) && (32'(y_q) < VEnd);

  always_ff @(posedge O_CLK or posedge RST) begin
    if (RST) begin
      x_q             <= '0;
      y_q             <= '0;
      frame_q         <= '0;
      to_q            <= '0;
      PULSE_1HZ       <= 1'b0;
      LINES_PER_FRAME <= '0;
    end else begin
      to_q <= vs_edge ? '0 : (timeout ? to_q : to_q + TO_W'(1));
      if (ENABLE) begin
        if (hs_act)         x_q <= '0;
        else if (x_q != '1) x_q <= x_q + XW'(1);
        // VS wins over a coincident HS edge.
        if (vs_act)                     y_q <= '0;
        else if (hs_edge && y_q != '1)  y_q <= y_q + YW'(1);
      end
      if (vs_ev) begin
        LINES_PER_FRAME <= y_q;
        if (32'(frame_q) >= PULSE_DIV - 1) begin
          frame_q   <= '0;
          PULSE_1HZ <= ~PULSE_1HZ;
        end else begin
          frame_q <= frame_q + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge O_CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StUnlocked;
      ref_lines_q <= '0;
      match_q     <= '0;
      LOCKED      <= 1'b0;
    end else begin
      LOCKED <= (state_q == StLocked);
      if (!ENABLE || timeout || hs_pchg || vs_pchg) begin
        state_q <= StUnlocked;
        match_q <= '0;
      end else if (vs_ev) begin
        unique case (state_q)
          StUnlocked: begin
            state_q     <= StAcquire;
            ref_lines_q <= y_q;
            match_q     <= '0;
          end
          StAcquire: begin
            // A zero-line frame (sync held active) never counts as a match.
            if (y_q == ref_lines_q && y_q != '0) begin
              match_q <= match_q + MW'(1);
              if (32'(match_q) + 1 >= LOCK_FRAMES - 1) state_q <= StLocked;
            end else begin
              ref_lines_q <= y_q;
              match_q     <= '0;
            end
          end
          StLocked: begin
            if (y_q != ref_lines_q) state_q <= StUnlocked;
          end
          default: state_q <= StUnlocked;
        endcase
      end
    end
  end

  always_ff @(posedge O_CLK or posedge RST) begin
    if (RST) begin
      O_X       <= '0;
      O_Y       <= '0;
      O_VISIBLE <= 1'b0;
      SYNC      <= 1'b0;
    end else begin
      O_X       <= x_q - XW'(H_FRONT_PORCH);
      O_Y       <= y_q - YW'(V_FRONT_PORCH);
      O_VISIBLE <= ENABLE & (state_q == StLocked) & in_win;
      SYNC      <= (32'(y_q) == SYNC_LINE);
    end
  end

endmodule

// File: tb/tb_o_timing_tracker.sv
// Directed bench for o_timing_tracker on a shrunken raster (32-clock lines, 12-line frames).
module tb_o_timing_tracker;

  localparam int unsigned XW = 6, YW = 5, HFP = 6, HV = 20, VFP = 2, VV = 8;
  localparam int unsigned PDIV = 4, SLINE = 3, LF = 3, TOW = 9;
  localparam int LineLen = 32, FrameLines = 12;
  localparam logic HsPol = 1'b0, VsPol = 1'b0;
  localparam logic [YW-1:0] SyncOy = YW'(SLINE - VFP);

  logic          O_CLK = 1'b0, RST, ENABLE, O_HS, O_VS;
  logic [XW-1:0] O_X;
  logic [YW-1:0] O_Y, LINES_PER_FRAME;
  logic          O_VISIBLE, PULSE_1HZ, SYNC, LOCKED;

  int   n_checks = 0, n_fail = 0;
  int   line_vis = 0, vis_lines = 0, vis_total = 0, bad_span = 0;
  int   first_x = -1, second_x = -1, toggles = 0, sync_hits = 0, sync_bad = 0;
  int   locked_hits = 0;
  logic prev_pulse = 1'b0;

  o_timing_tracker #(
    .XW(XW), .YW(YW), .H_FRONT_PORCH(HFP), .H_VISIBLE(HV), .V_FRONT_PORCH(VFP),
    .V_VISIBLE(VV), .HS_POL(HsPol), .VS_POL(VsPol), .PULSE_DIV(PDIV),
    .SYNC_LINE(SLINE), .LOCK_FRAMES(LF), .TO_W(TOW)
  ) dut (
    .O_CLK(O_CLK), .RST(RST), .ENABLE(ENABLE), .O_HS(O_HS), .O_VS(O_VS),
    .O_X(O_X), .O_Y(O_Y), .O_VISIBLE(O_VISIBLE), .PULSE_1HZ(PULSE_1HZ),
    .SYNC(SYNC), .LOCKED(LOCKED), .LINES_PER_FRAME(LINES_PER_FRAME)
  );

  always #5 O_CLK = ~O_CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic hs_lvl, input logic vs_lvl);
    O_HS = hs_lvl;
    O_VS = vs_lvl;
    @(posedge O_CLK);
    #1;
    if (O_VISIBLE) begin
      if (line_vis == 0) first_x = int'(O_X);
      else if (line_vis == 1) second_x = int'(O_X);
      line_vis++;
    end
    if (PULSE_1HZ !== prev_pulse) toggles++;
    prev_pulse = PULSE_1HZ;
    if (SYNC) sync_hits++;
    if (SYNC !== (O_Y == SyncOy)) sync_bad++;
    if (LOCKED) locked_hits++;
  endtask

  // HS active for cycles 0-1; optional VS pulse on cycles 4-9, clear of the HS edge.
  task automatic run_line(input bit vs, input bit inv, input int from, input int to);
    for (int c = from; c < to; c++) begin
      logic hs_a, vs_a;
      hs_a = (c < 2);
      vs_a = vs && (c >= 4) && (c < 10);
      tick((hs_a ? HsPol : ~HsPol) ^ inv, (vs_a ? VsPol : ~VsPol) ^ inv);
    end
    if (to == LineLen) begin
      if (line_vis != 0) begin
        vis_lines++;
        vis_total += line_vis;
        if (line_vis != int'(HV)) bad_span++;
      end
      line_vis = 0;
    end
  endtask

  task automatic run_frame(input int nlines, input bit inv);
    run_line(1'b1, inv, 0, LineLen);
    for (int l = 1; l < nlines; l++) run_line(1'b0, inv, 0, LineLen);
  endtask

  task automatic clear_stats();
    line_vis = 0; vis_lines = 0; vis_total = 0; bad_span = 0;
    first_x = -1; second_x = -1; sync_hits = 0; sync_bad = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " O_X"}, int'(O_X), 0);
    chk({tag, " O_Y"}, int'(O_Y), 0);
    chk({tag, " O_VISIBLE"}, int'(O_VISIBLE), 0);
    chk({tag, " SYNC"}, int'(SYNC), 0);
    chk({tag, " PULSE_1HZ"}, int'(PULSE_1HZ), 0);
    chk({tag, " LOCKED"}, int'(LOCKED), 0);
    chk({tag, " LINES_PER_FRAME"}, int'(LINES_PER_FRAME), 0);
  endtask

  initial begin
    RST = 1'b1; ENABLE = 1'b1; O_HS = ~HsPol; O_VS = ~VsPol;
    for (int i = 0; i < 4; i++) tick(~HsPol, ~VsPol);
    chk_all_zero("reset");
    RST = 1'b0;

    // First edge measures a 1-line partial frame; lock lands on the 4th edge.
    run_frame(FrameLines, 1'b0);
    chk("f1 locked", int'(LOCKED), 0);
    chk("f1 lines", int'(LINES_PER_FRAME), 1);
    run_frame(FrameLines, 1'b0);
    chk("f2 locked", int'(LOCKED), 0);
    chk("f2 lines", int'(LINES_PER_FRAME), 12);
    run_frame(FrameLines, 1'b0);
    chk("f3 locked", int'(LOCKED), 0);
    clear_stats();
    run_frame(FrameLines, 1'b0);
    chk("f4 locked", int'(LOCKED), 1);
    chk("f4 visible lines", vis_lines, 8);
    chk("f4 visible cycles", vis_total, 160);
    chk("f4 bad spans", bad_span, 0);
    chk("f4 first O_X", first_x, 63);
    chk("f4 second O_X", second_x, 0);
    chk("f4 toggles", toggles, 1);

    clear_stats();
    run_frame(FrameLines, 1'b0);
    chk("f5 sync cycles", sync_hits, LineLen);
    chk("f5 sync vs O_Y", sync_bad, 0);
    for (int f = 6; f <= 8; f++) run_frame(FrameLines, 1'b0);
    chk("f8 toggles", toggles, 2);
    chk("f8 locked", int'(LOCKED), 1);

    // One short frame drops lock; reacquire takes three more edges.
    run_frame(FrameLines - 1, 1'b0);
    run_frame(FrameLines, 1'b0);
    chk("short drop", int'(LOCKED), 0);
    chk("short lines", int'(LINES_PER_FRAME), 11);
    run_frame(FrameLines, 1'b0);
    chk("relock a", int'(LOCKED), 0);
    run_frame(FrameLines, 1'b0);
    chk("relock b", int'(LOCKED), 0);
    run_frame(FrameLines, 1'b0);
    chk("relock c", int'(LOCKED), 1);

    for (int l = 0; l < 3; l++) run_line(1'b0, 1'b0, 0, LineLen);
    chk("pre-timeout", int'(LOCKED), 1);
    for (int l = 0; l < 3; l++) run_line(1'b0, 1'b0, 0, LineLen);
    chk("timeout", int'(LOCKED), 0);
    for (int f = 0; f < 4; f++) run_frame(FrameLines, 1'b0);
    chk("post-timeout lock", int'(LOCKED), 1);

    run_line(1'b1, 1'b0, 0, LineLen);
    for (int l = 1; l <= 4; l++) run_line(1'b0, 1'b0, 0, LineLen);
    chk("line4 O_Y", int'(O_Y), 2);
    ENABLE = 1'b0;
    clear_stats();
    run_line(1'b0, 1'b0, 0, LineLen);
    chk("disable locked", int'(LOCKED), 0);
    chk("disable visible", vis_total, 0);
    chk("disable O_Y hold", int'(O_Y), 2);
    ENABLE = 1'b1;

    // Reset mid-line, release while HS is inactive.
    run_line(1'b0, 1'b0, 0, 15);
    RST = 1'b1;
    #1;
    chk_all_zero("mid-line reset");
    run_line(1'b0, 1'b0, 15, 17);
    RST = 1'b0;
    run_line(1'b0, 1'b0, 17, LineLen);
    chk("post-reset O_Y", int'(O_Y), 30);
    for (int l = 7; l < FrameLines; l++) run_line(1'b0, 1'b0, 0, LineLen);
    run_frame(FrameLines, 1'b0);
    chk("rst f1 lines", int'(LINES_PER_FRAME), 6);
    chk("rst f1 locked", int'(LOCKED), 0);
    run_frame(FrameLines, 1'b0);
    run_frame(FrameLines, 1'b0);
    chk("rst f3 locked", int'(LOCKED), 0);
    run_frame(FrameLines, 1'b0);
    chk("rst f4 locked", int'(LOCKED), 1);

`ifdef O_TRACKER_POLDET_EN
    for (int f = 0; f < 12; f++) run_frame(FrameLines, 1'b1);
    chk("inverted lock", int'(LOCKED), 1);
`else
    run_frame(FrameLines, 1'b1);
    locked_hits = 0;
    for (int f = 0; f < 6; f++) run_frame(FrameLines, 1'b1);
    chk("inverted never locks", locked_hits, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
